// File: rtl/sh4_fpu_unpack_pkg.sv
// Shared SH4 FPU defines: field widths, exponent constants, unpack FSM states
// and the unpacked-operand record.
package sh4_fpu_unpack_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int IDX_W  = 4;

  localparam logic [EXP_W-1:0] EXP_ZERO = 8'h00;
  localparam logic [EXP_W-1:0] EXP_MAX  = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_A  = 3'd1,
    ST_RD_B  = 3'd2,
    ST_CAP_B = 3'd3,
    ST_OUT   = 3'd4
  } unpack_state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
    logic              is_zero;
    logic              is_inf;
    logic              is_nan;
    logic              is_denorm;
  } fp_unpacked_t;

endpackage

// File: rtl/sh4_fpu_unpack_classify.sv
// Splits an IEEE-754 single into sign/exponent/fraction and a one-hot-or-none
// class; denormals are flushed to signed zero when dn is set.
module sh4_fpu_classify
  import sh4_fpu_unpack_pkg::*;
(
  input  logic [31:0]       word,
  input  logic              dn,
  output logic              sign,
  output logic [EXP_W-1:0]  exp,
  output logic [FRAC_W-1:0] frac,
  output logic              is_zero,
  output logic              is_inf,
  output logic              is_nan,
  output logic              is_denorm
);

  logic [EXP_W-1:0]  exp_in;
  logic [FRAC_W-1:0] frac_in;

  assign exp_in  = word[FRAC_W +: EXP_W];
  assign frac_in = word[FRAC_W-1:0];

  // NaN payloads pass through untouched so downstream can test frac[22] for sNaN.
  always_comb begin
    sign      = word[31];
    exp       = exp_in;
    frac      = frac_in;
    is_zero   = 1'b0;
    is_inf    = 1'b0;
    is_nan    = 1'b0;
    is_denorm = 1'b0;
    if (exp_in == EXP_ZERO) begin
      if (frac_in == '0) begin
        is_zero = 1'b1;
      end else if (dn) begin
        is_zero = 1'b1;
        frac    = '0;
      end else begin
        is_denorm = 1'b1;
      end
    end else if (exp_in == EXP_MAX) begin
      if (frac_in == '0) is_inf = 1'b1;
      else               is_nan = 1'b1;
    end
  end

endmodule

// File: rtl/sh4_fpu_unpack.sv
// Operand fetch/unpack stage: reads FR[A] then FR[B] from a one-cycle-latency
// register file, classifies each word and presents both until o_ready.
module sh4_fpu_unpack
  import sh4_fpu_unpack_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [IDX_W-1:0]  req_a_idx,
  input  logic [IDX_W-1:0]  req_b_idx,
  input  logic              req_dn,
  input  logic              flush,
  output logic              rf_ren,
  output logic [IDX_W-1:0]  rf_raddr,
  input  logic [31:0]       rf_rdata,
  output logic              o_valid,
  input  logic              o_ready,
  output logic              a_sign,
  output logic [EXP_W-1:0]  a_exp,
  output logic [FRAC_W-1:0] a_frac,
  output logic              a_is_zero,
  output logic              a_is_inf,
  output logic              a_is_nan,
  output logic              a_is_denorm,
  output logic              b_sign,
  output logic [EXP_W-1:0]  b_exp,
  output logic [FRAC_W-1:0] b_frac,
  output logic              b_is_zero,
  output logic              b_is_inf,
  output logic              b_is_nan,
  output logic              b_is_denorm
);

  unpack_state_t    state;
  logic [IDX_W-1:0] a_idx_q;
  logic [IDX_W-1:0] b_idx_q;
  logic             dn_q;
  fp_unpacked_t     cls;
  fp_unpacked_t     a_q;
  fp_unpacked_t     b_q;

  sh4_fpu_classify u_classify (
    .word      (rf_rdata),
    .dn        (dn_q),
    .sign      (cls.sign),
    .exp       (cls.exp),
    .frac      (cls.frac),
    .is_zero   (cls.is_zero),
    .is_inf    (cls.is_inf),
    .is_nan    (cls.is_nan),
    .is_denorm (cls.is_denorm)
  );

  // Handshake and RF outputs are flops loaded with the value of the state being
  // entered, so none of them has a combinational path from any input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      rf_ren    <= 1'b0;
      rf_raddr  <= '0;
      o_valid   <= 1'b0;
      a_idx_q   <= '0;
      b_idx_q   <= '0;
      dn_q      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
    end else if (flush) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      rf_ren    <= 1'b0;
      rf_raddr  <= '0;
      o_valid   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            a_idx_q   <= req_a_idx;
            b_idx_q   <= req_b_idx;
            dn_q      <= req_dn;
            state     <= ST_RD_A;
            req_ready <= 1'b0;
            rf_ren    <= 1'b1;
            rf_raddr  <= req_a_idx;
          end
        end
        ST_RD_A: begin
          state    <= ST_RD_B;
          rf_raddr <= b_idx_q;
        end
        // rf_rdata now carries FR[A], requested during RD_A.
        ST_RD_B: begin
          a_q      <= cls;
          state    <= ST_CAP_B;
          rf_ren   <= 1'b0;
          rf_raddr <= '0;
        end
        ST_CAP_B: begin
          b_q     <= cls;
          state   <= ST_OUT;
          o_valid <= 1'b1;
        end
        ST_OUT: begin
          if (o_ready) begin
            state     <= ST_IDLE;
            o_valid   <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          rf_ren    <= 1'b0;
          rf_raddr  <= '0;
          o_valid   <= 1'b0;
        end
      endcase
    end
  end

  assign a_sign      = a_q.sign;
  assign a_exp       = a_q.exp;
  assign a_frac      = a_q.frac;
  assign a_is_zero   = a_q.is_zero;
  assign a_is_inf    = a_q.is_inf;
  assign a_is_nan    = a_q.is_nan;
  assign a_is_denorm = a_q.is_denorm;
  assign b_sign      = b_q.sign;
  assign b_exp       = b_q.exp;
  assign b_frac      = b_q.frac;
  assign b_is_zero   = b_q.is_zero;
  assign b_is_inf    = b_q.is_inf;
  assign b_is_nan    = b_q.is_nan;
  assign b_is_denorm = b_q.is_denorm;

endmodule

// File: tb/tb_sh4_fpu_unpack.sv
// Self-checking bench for sh4_fpu_unpack: directed corner cases plus random
// operands checked against a behavioural IEEE-754 classification model.
module tb_sh4_fpu_unpack;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_a_idx;
  logic [3:0]  req_b_idx;
  logic        req_dn;
  logic        flush;
  logic        rf_ren;
  logic [3:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        o_valid;
  logic        o_ready;
  logic        a_sign, b_sign;
  logic [7:0]  a_exp, b_exp;
  logic [22:0] a_frac, b_frac;
  logic        a_is_zero, a_is_inf, a_is_nan, a_is_denorm;
  logic        b_is_zero, b_is_inf, b_is_nan, b_is_denorm;

  logic [31:0] rf_mem [16];
  int          tests_run = 0;
  int          tests_failed = 0;

  always #5 clk = ~clk;

  sh4_fpu_unpack dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a_idx(req_a_idx), .req_b_idx(req_b_idx), .req_dn(req_dn),
    .flush(flush),
    .rf_ren(rf_ren), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .o_valid(o_valid), .o_ready(o_ready),
    .a_sign(a_sign), .a_exp(a_exp), .a_frac(a_frac),
    .a_is_zero(a_is_zero), .a_is_inf(a_is_inf), .a_is_nan(a_is_nan), .a_is_denorm(a_is_denorm),
    .b_sign(b_sign), .b_exp(b_exp), .b_frac(b_frac),
    .b_is_zero(b_is_zero), .b_is_inf(b_is_inf), .b_is_nan(b_is_nan), .b_is_denorm(b_is_denorm)
  );

  // Register file with one cycle of read latency; garbage when not enabled.
  always @(posedge clk) rf_rdata <= rf_ren ? rf_mem[rf_raddr] : 32'h0BAD_F00D;

  function automatic logic [35:0] pack_a();
    return {a_sign, a_exp, a_frac, a_is_zero, a_is_inf, a_is_nan, a_is_denorm};
  endfunction

  function automatic logic [35:0] pack_b();
    return {b_sign, b_exp, b_frac, b_is_zero, b_is_inf, b_is_nan, b_is_denorm};
  endfunction

  // Reference: {sign, exp, frac, zero, inf, nan, denorm} from the IEEE rules.
  function automatic logic [35:0] model(input logic [31:0] w, input logic dn);
    int unsigned e;
    int unsigned f;
    logic z, i, n, d;
    e = w[30:23];
    f = w[22:0];
    z = 1'b0; i = 1'b0; n = 1'b0; d = 1'b0;
    if (e == 255) begin
      if (f == 0) i = 1'b1;
      else        n = 1'b1;
    end else if (e == 0) begin
      if (f == 0)  z = 1'b1;
      else if (dn) begin z = 1'b1; f = 0; end
      else         d = 1'b1;
    end
    return {w[31], 8'(e), 23'(f), z, i, n, d};
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 5))
      0: w[30:0] = '0;
      1: begin w[30:23] = 8'h00; if (w[22:0] == '0) w[0] = 1'b1; end
      2: begin w[30:23] = 8'hFF; w[22:0] = '0; end
      3: begin w[30:23] = 8'hFF; if (w[22:0] == '0) w[22] = 1'b1; end
      default: ;
    endcase
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [35:0] obs, input logic [35:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full request: accept, two reads, capture, hold for 'stall' cycles, release.
  task automatic applyStimulus(input logic [3:0] ai, input logic [3:0] bi, input logic dn,
                               input int stall);
    logic [35:0] ea, eb;
    ea = model(rf_mem[ai], dn);
    eb = model(rf_mem[bi], dn);
    checkOutput("idle_ready", 36'(req_ready), 36'd1);
    req_valid = 1'b1; req_a_idx = ai; req_b_idx = bi; req_dn = dn;
    tick();
    req_valid = 1'b0; req_a_idx = 4'($urandom); req_b_idx = 4'($urandom); req_dn = 1'($urandom);
    checkOutput("rd_a_rf", 36'({rf_ren, rf_raddr}), 36'({1'b1, ai}));
    checkOutput("rd_a_hs", 36'({req_ready, o_valid}), 36'd0);
    tick();
    checkOutput("rd_b_rf", 36'({rf_ren, rf_raddr}), 36'({1'b1, bi}));
    checkOutput("rd_b_hs", 36'({req_ready, o_valid}), 36'd0);
    tick();
    checkOutput("cap_b_ren", 36'({rf_ren, o_valid, req_ready}), 36'd0);
    tick();
    checkOutput("latency_o_valid", 36'(o_valid), 36'd1);
    checkOutput("a_fields", pack_a(), ea);
    checkOutput("b_fields", pack_b(), eb);
    for (int k = 0; k < stall; k++) begin
      tick();
      checkOutput("stall_hs", 36'({o_valid, req_ready, rf_ren}), 36'b100);
      checkOutput("stall_a", pack_a(), ea);
      checkOutput("stall_b", pack_b(), eb);
    end
    o_ready = 1'b1;
    tick();
    o_ready = 1'b0;
    checkOutput("release_hs", 36'({o_valid, req_ready}), 36'b01);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_a_idx = '0; req_b_idx = '0; req_dn = 1'b0;
    flush = 1'b0; o_ready = 1'b0;
    for (int k = 0; k < 16; k++) rf_mem[k] = 32'h0;
    repeat (2) tick();
    checkOutput("reset_hs", 36'({req_ready, o_valid, rf_ren, rf_raddr}), 36'b1000000);
    checkOutput("reset_a", pack_a(), 36'd0);
    checkOutput("reset_b", pack_b(), 36'd0);
    rst = 1'b0;

    // +1.0 / -1.0
    rf_mem[1] = 32'h3F80_0000; rf_mem[2] = 32'hBF80_0000;
    applyStimulus(4'd1, 4'd2, 1'b0, 0);
    checkOutput("one_a_lit", pack_a(), {1'b0, 8'h7F, 23'h0, 4'b0000});

    // Infinity and quiet NaN
    rf_mem[3] = 32'h7F80_0000; rf_mem[4] = 32'h7FC0_0000;
    applyStimulus(4'd3, 4'd4, 1'b1, 0);
    checkOutput("nan_b_lit", pack_b(), {1'b0, 8'hFF, 23'h40_0000, 4'b0010});

    // Smallest denormal, flushed then kept; same index for A and B
    rf_mem[5] = 32'h0000_0001;
    applyStimulus(4'd5, 4'd5, 1'b1, 0);
    checkOutput("dn1_a_lit", pack_a(), {1'b0, 8'h00, 23'h0, 4'b1000});
    applyStimulus(4'd5, 4'd5, 1'b0, 0);
    checkOutput("dn0_a_lit", pack_a(), {1'b0, 8'h00, 23'h1, 4'b0001});

    // Back-pressure for 6 cycles, then immediate next request
    applyStimulus(4'd1, 4'd4, 1'b0, 6);
    applyStimulus(4'd2, 4'd3, 1'b0, 0);

    // Flush in IDLE blocks acceptance
    req_valid = 1'b1; flush = 1'b1; req_a_idx = 4'd1; req_b_idx = 4'd2;
    tick();
    req_valid = 1'b0; flush = 1'b0;
    checkOutput("flush_idle", 36'({req_ready, rf_ren, o_valid}), 36'b100);

    // Flush in RD_B: back to IDLE, no read in the CAP_B slot, never o_valid
    req_valid = 1'b1; req_a_idx = 4'd3; req_b_idx = 4'd4;
    tick();
    req_valid = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flush_rdb", 36'({req_ready, rf_ren, o_valid}), 36'b100);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput("flush_no_valid", 36'({o_valid, rf_ren}), 36'd0);
    end

    // Asynchronous reset in CAP_B
    req_valid = 1'b1; req_a_idx = 4'd1; req_b_idx = 4'd2; req_dn = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    checkOutput("async_rst_hs", 36'({req_ready, o_valid, rf_ren, rf_raddr}), 36'b1000000);
    checkOutput("async_rst_a", pack_a(), 36'd0);
    checkOutput("async_rst_b", pack_b(), 36'd0);
    tick();
    rst = 1'b0;
    applyStimulus(4'd3, 4'd1, 1'b0, 0);

    // Random operands and back-pressure
    for (int t = 0; t < 30; t++) begin
      logic [3:0] ai, bi;
      ai = 4'($urandom); bi = 4'($urandom);
      rf_mem[ai] = rand_word();
      rf_mem[bi] = rand_word();
      applyStimulus(ai, bi, 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sh4_fpu_unpack.md
SH4_FPU_UNPACK -- requirements
Module: sh4_fpu_unpack

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 req_valid / req_ready  in / out  1 / 1  operand-fetch request handshake; transfer when both high on a clk edge.
REQ-004 req_a_idx, req_b_idx  in  4 each  FR register indices for operands A and B.
REQ-005 req_dn  in  1  FPSCR.DN snapshot; 1 = flush denormals to zero.
REQ-006 flush  in  1  synchronous abort of any in-flight request.
REQ-007 rf_ren  out  1  register-file read enable; read data returns exactly one cycle later.
REQ-008 rf_raddr  out  4  register-file read address.
REQ-009 rf_rdata  in  32  register-file read data, IEEE-754 single.
REQ-010 o_valid / o_ready  out / in  1 / 1  unpacked-operand handshake to the compare/arith stage.
REQ-011 a_sign, b_sign  out  1 each  sign bit.
REQ-012 a_exp, b_exp  out  8 each  biased exponent.
REQ-013 a_frac, b_frac  out  23 each  fraction field.
REQ-014 a_is_zero, a_is_inf, a_is_nan, a_is_denorm (and b_ equivalents)  out  1 each  class flags.

Function
REQ-015 FSM states IDLE, RD_A, RD_B, CAP_B, OUT; encoding is an implementation choice.
REQ-016 IDLE: req_ready=1; on req_valid latch indices and dn, go RD_A; req_ready=0 in all other states.
REQ-017 RD_A: rf_ren=1, rf_raddr=latched A index; go RD_B.
REQ-018 RD_B: rf_ren=1, rf_raddr=latched B index; capture classified rf_rdata into A fields; go CAP_B.
REQ-019 CAP_B: rf_ren=0; capture classified rf_rdata into B fields; go OUT.
REQ-020 OUT: o_valid=1; all a_*/b_* outputs held stable; on o_ready go IDLE; else remain.
REQ-021 Latency: accept at edge N yields o_valid=1 in cycle N+4; throughput one request per 5 cycles minimum.
REQ-022 rf_ren, rf_raddr, req_ready, o_valid decoded from the state register only; no combinational path from req_valid, o_ready or rf_rdata.
REQ-023 Classification: zero = exp 0 & frac 0; inf = exp FF & frac 0; nan = exp FF & frac!=0; denorm = exp 0 & frac!=0.
REQ-024 Denorm with dn=1: is_zero=1, is_denorm=0, frac output 0, sign and exp(0) preserved.
REQ-025 Denorm with dn=0: is_denorm=1, is_zero=0, fields passed unmodified.
REQ-026 NaN fraction passed unmodified; frac[22]=1 identifies sNaN downstream (SH4 convention).
REQ-027 req_a_idx == req_b_idx permitted; two reads still issued, identical A/B fields result.
REQ-028 flush=1 in any state: next state IDLE, o_valid=0 next cycle, captured fields may remain; flush in IDLE with req_valid: request not accepted.
REQ-029 Exactly one class flag or none (normal) asserted per operand.

Reset
REQ-030 rst=1 forces immediately: state IDLE, o_valid=0, rf_ren=0, rf_raddr=0, all a_*/b_* fields and flags 0, latched indices and dn 0.
REQ-031 rst mid-operation discards the request without o_valid; first accept possible on first edge after rst deasserts.

Structure
REQ-032 Field widths (8/23), exponent constants 8'h00/8'hFF and state encodings reside in the shared FPU defines header.
REQ-033 One combinational sub-module sh4_fpu_classify (32-bit word + dn -> sign/exp/frac/flags), instantiated once on rf_rdata.

Verification
REQ-034 A=0x3F800000, B=0xBF800000 -> a: sign0 exp 7F frac 0 all flags 0; b: sign1 same; o_valid exactly 4 cycles after accept.
REQ-035 A=0x7F800000, B=0x7FC00000 -> a_is_inf=1; b_is_nan=1, b_frac=0x400000 (frac[22]=1).
REQ-036 A=0x00000001, dn=1 -> a_is_zero=1, a_frac=0, a_is_denorm=0; repeat dn=0 -> a_is_denorm=1, a_frac=1.
REQ-037 o_ready low 6 cycles in OUT -> outputs stable, req_ready=0, rf_ren=0 throughout; accept next request the cycle after o_ready.
REQ-038 flush asserted in RD_B -> IDLE next cycle, no o_valid ever for that request, rf_ren=0 in CAP_B slot.
REQ-039 rst asserted asynchronously mid-CAP_B -> o_valid, rf_ren, all fields 0 before next edge; clean request after release completes normally.
